// File: rtl/axis_beam_splitter_pkg.sv
// Shared types and constants for the four-way transmit beam splitter.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package axis_beam_pkg;

  localparam int NUM_CH     = 4;
  localparam int SAMPLE_W   = 16;
  localparam int LANES      = 8;
  localparam int DATA_W     = LANES * SAMPLE_W;
  localparam int WEIGHT_W   = 8;
  localparam int FRAC_BITS  = 6;
  // Full-precision product of one sample and one weight.
  localparam int PROD_W     = SAMPLE_W + WEIGHT_W;

  typedef logic signed [WEIGHT_W-1:0] weight_t;
  typedef logic signed [SAMPLE_W-1:0] sample_t;

  localparam weight_t UNITY_WEIGHT = weight_t'(1 << FRAC_BITS);
  localparam sample_t SAT_MAX      = 16'sh7FFF;
  localparam sample_t SAT_MIN      = 16'sh8000;

endpackage

// File: rtl/axis_beam_splitter_if.sv
// AXI-Stream bundle (tdata/tvalid/tready/tlast) with master and slave views.
// Latency: n/a (wiring only).
// Backpressure: tready travels against the data direction.
interface axis_beam_splitter_if
  import axis_beam_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_W
) ();

  logic [DATA_WIDTH-1:0] tdata;
  logic                  tvalid;
  logic                  tready;
  logic                  tlast;

  modport master (output tdata, output tvalid, output tlast, input tready);
  modport slave  (input tdata, input tvalid, input tlast, output tready);

endinterface

// File: rtl/axis_beam_splitter_lane.sv
// Scales one signed sample by a signed fixed-point weight, clamps to 16 bits.
// Latency: combinational.
// Backpressure: none.
// Ports: sample_i (16s), weight_i (8s, FRAC fractional bits) -> result_o (16s), sat_o (clamp hit).
module weight_scale_lane
  import axis_beam_pkg::*;
#(
  parameter int FRAC = FRAC_BITS
) (
  input  sample_t sample_i,
  input  weight_t weight_i,
  output sample_t result_o,
  output logic    sat_o
);

  localparam logic signed [PROD_W-1:0] RES_MAX = PROD_W'(SAT_MAX);
  localparam logic signed [PROD_W-1:0] RES_MIN = PROD_W'(SAT_MIN);

  logic signed [PROD_W-1:0] prod;
  logic signed [PROD_W-1:0] res;

  always_comb begin
    prod     = PROD_W'(sample_i) * PROD_W'(weight_i);
    // Arithmetic shift floors toward minus infinity, not toward zero.
    res      = prod >>> FRAC;
    result_o = res[SAMPLE_W-1:0];
    sat_o    = 1'b0;
    if (res > RES_MAX) begin
      result_o = SAT_MAX;
      sat_o    = 1'b1;
    end else if (res < RES_MIN) begin
      result_o = SAT_MIN;
      sat_o    = 1'b1;
    end
  end

endmodule

// File: rtl/axis_beam_splitter.sv
// Fans one AXI-Stream of 8x16b samples out to four weighted, saturated streams.
// Latency: 1 cycle from input acceptance to all four output registers.
// Backpressure: input ready only when every channel can take a beat (any stalled channel stalls input).
// Ports: CLK/resetn (sync, active-low); s00_axis slave in; m00/m01/m20/m21_axis masters (ch 0..3);
//        weight_wr/weight_sel/weight_data shadow-weight write; sat_flag sticky clamp flags, sat_clr clears.
module axis_beam_splitter
  import axis_beam_pkg::*;
#(
  parameter int SDATA_WIDTH  = DATA_W,
  parameter int SAMPLE_WIDTH = SAMPLE_W,
  parameter int WEIGHT_WIDTH = WEIGHT_W,
  parameter int WEIGHT_FRAC  = FRAC_BITS
) (
  input  logic                           CLK,
  input  logic                           resetn,
  axis_beam_splitter_if.slave            s00_axis,
  axis_beam_splitter_if.master           m00_axis,
  axis_beam_splitter_if.master           m01_axis,
  axis_beam_splitter_if.master           m20_axis,
  axis_beam_splitter_if.master           m21_axis,
  input  logic                           weight_wr,
  input  logic [1:0]                     weight_sel,
  input  logic signed [WEIGHT_WIDTH-1:0] weight_data,
  output logic [NUM_CH-1:0]              sat_flag,
  input  logic                           sat_clr
);

  logic [NUM_CH-1:0][SDATA_WIDTH-1:0] data_q, data_d, scaled;
  logic [NUM_CH-1:0][LANES-1:0]       lane_sat;
  logic [NUM_CH-1:0]                  valid_q, valid_d, last_q, last_d;
  logic [NUM_CH-1:0]                  sat_q, sat_d;
  weight_t [NUM_CH-1:0]               shadow_q, shadow_d, active_q, active_d;
  logic                               in_pkt_q, in_pkt_d;
  logic [NUM_CH-1:0]                  m_rdy, can_load;
  logic                               s_rdy, accept;

  assign m_rdy = {m21_axis.tready, m20_axis.tready, m01_axis.tready, m00_axis.tready};

  // Only path from outputs back to the input is mXX_tready -> s_tready.
  assign can_load        = ~valid_q | m_rdy;
  assign s_rdy           = resetn & (&can_load);
  assign s00_axis.tready = s_rdy;
  assign accept          = s00_axis.tvalid & s_rdy;

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    for (genvar l = 0; l < LANES; l++) begin : g_lane
      weight_scale_lane #(.FRAC(WEIGHT_FRAC)) u_lane (
        .sample_i (s00_axis.tdata[l*SAMPLE_WIDTH +: SAMPLE_WIDTH]),
        .weight_i (active_q[c]),
        .result_o (scaled[c][l*SAMPLE_WIDTH +: SAMPLE_WIDTH]),
        .sat_o    (lane_sat[c][l])
      );
    end
  end

  always_comb begin
    data_d   = data_q;
    valid_d  = valid_q;
    last_d   = last_q;
    sat_d    = sat_clr ? '0 : sat_q;
    shadow_d = shadow_q;
    active_d = active_q;
    in_pkt_d = in_pkt_q;

    for (int c = 0; c < NUM_CH; c++) begin
      if (accept) begin
        data_d[c]  = scaled[c];
        last_d[c]  = s00_axis.tlast;
        valid_d[c] = 1'b1;
        // A fresh clamp on this beat beats a simultaneous clear.
        sat_d[c]   = sat_d[c] | (|lane_sat[c]);
      end else if (m_rdy[c]) begin
        valid_d[c] = 1'b0;
      end
    end

    if (weight_wr) begin
      shadow_d[weight_sel] = weight_t'(weight_data);
    end

    // Weights swap only at packet boundaries so one packet never mixes weight sets.
    // The swap takes the shadow value from before any same-cycle write.
    if ((!in_pkt_q && !accept) || (accept && s00_axis.tlast)) begin
      active_d = shadow_q;
    end

    if (accept) begin
      in_pkt_d = !s00_axis.tlast;
    end
  end

  always_ff @(posedge CLK) begin
    if (!resetn) begin
      data_q   <= '0;
      valid_q  <= '0;
      last_q   <= '0;
      sat_q    <= '0;
      shadow_q <= {NUM_CH{UNITY_WEIGHT}};
      active_q <= {NUM_CH{UNITY_WEIGHT}};
      in_pkt_q <= 1'b0;
    end else begin
      data_q   <= data_d;
      valid_q  <= valid_d;
      last_q   <= last_d;
      sat_q    <= sat_d;
      shadow_q <= shadow_d;
      active_q <= active_d;
      in_pkt_q <= in_pkt_d;
    end
  end

  assign sat_flag = sat_q;

  assign m00_axis.tdata  = data_q[0];
  assign m00_axis.tvalid = valid_q[0];
  assign m00_axis.tlast  = last_q[0];
  assign m01_axis.tdata  = data_q[1];
  assign m01_axis.tvalid = valid_q[1];
  assign m01_axis.tlast  = last_q[1];
  assign m20_axis.tdata  = data_q[2];
  assign m20_axis.tvalid = valid_q[2];
  assign m20_axis.tlast  = last_q[2];
  assign m21_axis.tdata  = data_q[3];
  assign m21_axis.tvalid = valid_q[3];
  assign m21_axis.tlast  = last_q[3];

endmodule

// File: tb/tb_axis_beam_splitter.sv
// Randomised and directed stimulus for the beam splitter, checked by a scoreboard.
// Latency: expects each accepted beat on every channel one cycle later, subject to ready.
// Backpressure: drives per-channel ready all-on, random, or on a fixed stall script.
module tb_axis_beam_splitter;

  typedef struct {
    logic [127:0] d;
    logic         l;
  } exp_t;

  logic         CLK = 1'b0;
  logic         resetn;
  logic         weight_wr;
  logic [1:0]   weight_sel;
  logic signed [7:0] weight_data;
  logic [3:0]   sat_flag;
  logic         sat_clr;

  logic [127:0] s_dat;
  logic         s_vld, s_last, s_rdy;
  logic [3:0]   m_rdy, m_vld, m_last;
  logic [127:0] m_dat [4];

  axis_beam_splitter_if #(.DATA_WIDTH(128)) s_if ();
  axis_beam_splitter_if #(.DATA_WIDTH(128)) m0_if ();
  axis_beam_splitter_if #(.DATA_WIDTH(128)) m1_if ();
  axis_beam_splitter_if #(.DATA_WIDTH(128)) m2_if ();
  axis_beam_splitter_if #(.DATA_WIDTH(128)) m3_if ();

  assign s_if.tdata   = s_dat;
  assign s_if.tvalid  = s_vld;
  assign s_if.tlast   = s_last;
  assign s_rdy        = s_if.tready;
  assign m0_if.tready = m_rdy[0];
  assign m1_if.tready = m_rdy[1];
  assign m2_if.tready = m_rdy[2];
  assign m3_if.tready = m_rdy[3];
  assign m_vld  = {m3_if.tvalid, m2_if.tvalid, m1_if.tvalid, m0_if.tvalid};
  assign m_last = {m3_if.tlast, m2_if.tlast, m1_if.tlast, m0_if.tlast};
  assign m_dat[0] = m0_if.tdata;
  assign m_dat[1] = m1_if.tdata;
  assign m_dat[2] = m2_if.tdata;
  assign m_dat[3] = m3_if.tdata;

  axis_beam_splitter dut (
    .CLK         (CLK),
    .resetn      (resetn),
    .s00_axis    (s_if),
    .m00_axis    (m0_if),
    .m01_axis    (m1_if),
    .m20_axis    (m2_if),
    .m21_axis    (m3_if),
    .weight_wr   (weight_wr),
    .weight_sel  (weight_sel),
    .weight_data (weight_data),
    .sat_flag    (sat_flag),
    .sat_clr     (sat_clr)
  );

  always #5 CLK = ~CLK;

  int tests = 0;
  int fails = 0;

  // Reference state: weights, packet tracking, sticky flags, expected beats.
  exp_t exp_q [4][$];
  int   shadow_m [4];
  int   active_m [4];
  logic in_pkt_m = 1'b0;
  logic [3:0] sat_m = 4'b0;

  // Directed one-cycle checks on {s_tready, m_tvalid[3:0], sat_flag[3:0]}.
  logic        dchk_en = 1'b0;
  logic [8:0]  dchk_exp = '0;
  logic [8:0]  dchk_mask = '0;
  string       dchk_name = "";
  logic        end_chk = 1'b0;

  int rdy_mode = 0;
  int cyc = 0;
  int scr_start = 0;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, want %h", nm, act, exp);
    end
  endtask

  // Behavioural scaling: floor(sample * w / 64), clamped to int16.
  function automatic logic [127:0] scale(input logic [127:0] d, input int w, output logic sat);
    logic [127:0] r;
    logic [15:0]  s16;
    int           v;
    r   = '0;
    sat = 1'b0;
    for (int i = 0; i < 8; i++) begin
      s16 = d[i*16 +: 16];
      v   = $signed(s16) * w;
      v   = v >>> 6;
      if (v > 32767) begin v = 32767; sat = 1'b1; end
      if (v < -32768) begin v = -32768; sat = 1'b1; end
      r[i*16 +: 16] = v[15:0];
    end
    return r;
  endfunction

  always @(posedge CLK) begin
    cyc++;
    #2;
    case (rdy_mode)
      1: m_rdy = 4'($urandom);
      2: begin
        m_rdy = 4'hF;
        if ((cyc - scr_start) >= 2 && (cyc - scr_start) <= 4) m_rdy[1] = 1'b0;
      end
      default: m_rdy = 4'hF;
    endcase
  end

  // Monitor and scoreboard: compares first, then advances the model for the coming edge.
  always @(negedge CLK) begin
    exp_t e;
    logic acc, bsat, pre_pkt;
    logic [127:0] r;
    int   pre_shadow [4];

    if (dchk_en)
      chk(dchk_name, 128'({s_rdy, m_vld, sat_flag} & dchk_mask), 128'(dchk_exp & dchk_mask));
    chk("sat_flag", 128'(sat_flag), 128'(sat_m));

    if (!resetn) begin
      for (int c = 0; c < 4; c++) begin
        exp_q[c].delete();
        shadow_m[c] = 64;
        active_m[c] = 64;
      end
      in_pkt_m = 1'b0;
      sat_m    = 4'b0;
    end else begin
      if (|(m_vld & ~m_rdy)) chk("s_tready_stall", 128'(s_rdy), 128'(0));
      for (int c = 0; c < 4; c++) begin
        if (m_vld[c] && m_rdy[c]) begin
          if (exp_q[c].size() == 0) begin
            tests++;
            fails++;
            $display("FAIL extra_beat ch%0d: got %h, want no beat", c, m_dat[c]);
          end else begin
            e = exp_q[c].pop_front();
            chk($sformatf("data ch%0d", c), m_dat[c], e.d);
            chk($sformatf("last ch%0d", c), 128'(m_last[c]), 128'(e.l));
          end
        end
      end

      acc     = s_vld && s_rdy;
      pre_pkt = in_pkt_m;
      for (int c = 0; c < 4; c++) pre_shadow[c] = shadow_m[c];
      if (sat_clr) sat_m = 4'b0;
      if (acc) begin
        for (int c = 0; c < 4; c++) begin
          r = scale(s_dat, active_m[c], bsat);
          exp_q[c].push_back('{d: r, l: s_last});
          if (bsat) sat_m[c] = 1'b1;
        end
        in_pkt_m = !s_last;
      end
      if ((!pre_pkt && !acc) || (acc && s_last))
        for (int c = 0; c < 4; c++) active_m[c] = pre_shadow[c];
      if (weight_wr) shadow_m[weight_sel] = int'(weight_data);
    end

    if (end_chk)
      for (int c = 0; c < 4; c++)
        chk($sformatf("drained ch%0d", c), 128'(exp_q[c].size()), 128'(0));
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge CLK);
      #1;
    end
  endtask

  task automatic dcheck(input string nm, input logic [8:0] exp, input logic [8:0] mask);
    dchk_name = nm;
    dchk_exp  = exp;
    dchk_mask = mask;
    dchk_en   = 1'b1;
    step(1);
    dchk_en   = 1'b0;
  endtask

  task automatic send(input logic [127:0] d, input logic l);
    int n;
    s_vld  = 1'b1;
    s_dat  = d;
    s_last = l;
    n = 0;
    do begin
      @(negedge CLK);
      n++;
    end while (!s_rdy && n < 300);
    if (!s_rdy) begin
      $display("FAIL send_timeout: got s_tready=0 for %0d cycles, want 1", n);
      $fatal(1, "input stalled");
    end
    @(posedge CLK);
    #1;
    s_vld = 1'b0;
  endtask

  task automatic wr_w(input logic [1:0] ch, input logic signed [7:0] w);
    weight_wr   = 1'b1;
    weight_sel  = ch;
    weight_data = w;
    step(1);
    weight_wr = 1'b0;
    step(2);
  endtask

  function automatic logic [127:0] fill(input logic [15:0] v);
    return {8{v}};
  endfunction

  task automatic drain();
    for (int i = 0; i < 100 && (exp_q[0].size() + exp_q[1].size() + exp_q[2].size() + exp_q[3].size()) > 0; i++)
      step(1);
  endtask

  initial begin
    logic [127:0] d;
    int len;

    resetn = 1'b0; s_vld = 1'b1; s_dat = '0; s_last = 1'b0;
    weight_wr = 1'b0; weight_sel = '0; weight_data = '0; sat_clr = 1'b0;
    m_rdy = 4'hF;

    // 1: reset holds input ready low, outputs idle, flags clear.
    step(1);
    dcheck("reset_cycle1", 9'b0, 9'h1FF);
    dcheck("reset_cycle2", 9'b0, 9'h1FF);
    s_vld  = 1'b0;
    resetn = 1'b1;
    dcheck("ready_after_reset", 9'h100, 9'h100);

    // 2: unity broadcast of lanes 1..8.
    for (int i = 0; i < 8; i++) d[i*16 +: 16] = 16'(i + 1);
    send(d, 1'b1);
    dcheck("broadcast_valid", 9'h0F0, 9'h0F0);
    step(2);

    // 3: distinct weights on each channel.
    wr_w(2'd0, -8'sd64);
    wr_w(2'd1, 8'sd32);
    wr_w(2'd2, 8'sd127);
    wr_w(2'd3, 8'sd0);
    send(fill(16'd1000), 1'b1);
    step(2);
    dcheck("scaling_no_sat", 9'h000, 9'h00F);

    // 4: saturation in both directions on ch2 only.
    wr_w(2'd0, 8'sd64);
    send(fill(16'h7FFF), 1'b1);
    send(fill(16'h8000), 1'b1);
    dcheck("sat_set", 9'h004, 9'h00F);
    sat_clr = 1'b1;
    step(1);
    sat_clr = 1'b0;
    dcheck("sat_cleared", 9'h000, 9'h00F);

    // 5: six-beat packet with ch1 stalled for three cycles.
    for (int c = 0; c < 4; c++) wr_w(2'(c), 8'sd64);
    scr_start = cyc;
    rdy_mode  = 2;
    for (int b = 1; b <= 6; b++) send(fill(16'(b)), b == 6);
    step(6);
    rdy_mode = 0;
    drain();

    // 6: weight written mid-packet applies only from the next packet.
    for (int b = 1; b <= 4; b++) begin
      if (b == 2) begin
        weight_wr = 1'b1; weight_sel = 2'd0; weight_data = 8'sd32;
      end
      send(fill(16'd64), b == 4);
      weight_wr = 1'b0;
    end
    step(1);
    send(fill(16'd64), 1'b1);
    step(2);

    // Randomised packets, weights, ready and flag clears.
    rdy_mode = 1;
    for (int p = 0; p < 40; p++) begin
      len = $urandom_range(1, 6);
      for (int b = 0; b < len; b++) begin
        d = {$urandom, $urandom, $urandom, $urandom};
        if ($urandom_range(0, 3) == 0) begin
          weight_wr   = 1'b1;
          weight_sel  = 2'($urandom);
          weight_data = 8'($urandom);
        end
        sat_clr = ($urandom_range(0, 7) == 0);
        send(d, b == len - 1);
        weight_wr = 1'b0;
        sat_clr   = 1'b0;
      end
      step($urandom_range(0, 2));
    end
    rdy_mode = 0;
    drain();

    // Reset mid-packet discards beats and restores unity weights.
    wr_w(2'd0, -8'sd64);
    send(fill(16'd300), 1'b0);
    resetn = 1'b0;
    s_vld  = 1'b1;
    step(1);
    dcheck("midpkt_reset", 9'b0, 9'h1FF);
    s_vld  = 1'b0;
    resetn = 1'b1;
    step(1);
    send(fill(16'd300), 1'b1);
    drain();

    end_chk = 1'b1;
    step(1);
    end_chk = 1'b0;
    step(1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
